// File: rtl/lsu_sram.sv
// ---------------------------------------------------------------------------
// lsu_sram
//   MEM-stage load/store unit. It accepts one memory op at a time and runs it
//   as a handshaked transaction on an SRAM-like data bus
//   (req / addr_ok / data_ok). It builds byte strobes and lane-replicated
//   store data, extracts and extends load data, and detects AdEL/AdES before
//   any bus request is issued. It also supports flush, with safe draining of
//   an access that the bus has already accepted.
//
//   Optional feature macro: LSU_UNALIGNED_EN
//     When defined, LWL/LWR/SWL/SWR (ops 9-12) are implemented.
//     When undefined, those codes behave like the reserved codes.
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     req_valid/ready   op handshake from the MEM stage (ready only in IDLE)
//     mem_op, addr      operation code and effective address
//     rt_data           store data / old rt value for LWL/LWR merging
//     i_except          exceptions raised by earlier stages
//     flush             cancel the current op; its result is discarded
//     resp_valid        one-cycle pulse carrying resp_data / o_except
//     bus_*             request channel to and response channel from the SRAM
// ---------------------------------------------------------------------------
module lsu_sram #(
  parameter int ADDR_W   = 32,
  parameter int EXC_W    = 7,
  parameter int ADEL_BIT = 1,
  parameter int ADES_BIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       rt_data,
  input  logic [EXC_W-1:0]  i_except,
  input  logic              flush,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic [EXC_W-1:0]  o_except,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_DRAIN, S_DONE} state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
`ifdef LSU_UNALIGNED_EN
  localparam logic [3:0] OP_LWL = 4'd9;
  localparam logic [3:0] OP_LWR = 4'd10;
  localparam logic [3:0] OP_SWL = 4'd11;
  localparam logic [3:0] OP_SWR = 4'd12;
`endif

  state_t           state;
  logic [3:0]       op_q;
  logic [1:0]       k_q;
  logic [EXC_W-1:0] exc_q;
  logic             resp_valid_q;
`ifdef LSU_UNALIGNED_EN
  logic [31:0]      rt_q;
`endif

  logic [1:0]       k_in;
  logic             is_load_in;
  logic             is_store_in;
  logic             adel_in;
  logic             ades_in;
  logic [3:0]       wstrb_in;
  logic [31:0]      wdata_in;
  logic [EXC_W-1:0] exc_in;
  logic             accept;
  logic             go_bus;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_data;

  assign k_in = addr[1:0];

  // Decode of the op currently presented: its class, its alignment error,
  // and the strobe/data it would put on the bus. Only used at accept time.
  always_comb begin
    is_load_in  = 1'b0;
    is_store_in = 1'b0;
    adel_in     = 1'b0;
    ades_in     = 1'b0;
    wstrb_in    = 4'b0000;
    wdata_in    = 32'd0;
    case (mem_op)
      OP_LB, OP_LBU: is_load_in = 1'b1;
      OP_LH, OP_LHU: begin
        is_load_in = 1'b1;
        adel_in    = k_in[0];
      end
      OP_LW: begin
        is_load_in = 1'b1;
        adel_in    = (k_in != 2'b00);
      end
      OP_SB: begin
        is_store_in = 1'b1;
        wstrb_in    = 4'b0001 << k_in;
        wdata_in    = {4{rt_data[7:0]}};
      end
      OP_SH: begin
        is_store_in = 1'b1;
        ades_in     = k_in[0];
        wstrb_in    = k_in[1] ? 4'b1100 : 4'b0011;
        wdata_in    = {2{rt_data[15:0]}};
      end
      OP_SW: begin
        is_store_in = 1'b1;
        ades_in     = (k_in != 2'b00);
        wstrb_in    = 4'b1111;
        wdata_in    = rt_data;
      end
`ifdef LSU_UNALIGNED_EN
      OP_LWL, OP_LWR: is_load_in = 1'b1;
      OP_SWL: begin
        is_store_in = 1'b1;
        wstrb_in    = 4'b1111 >> (2'd3 - k_in);
        wdata_in    = rt_data >> {2'd3 - k_in, 3'b000};
      end
      OP_SWR: begin
        is_store_in = 1'b1;
        wstrb_in    = 4'b1111 << k_in;
        wdata_in    = rt_data << {k_in, 3'b000};
      end
`endif
      default: ;
    endcase
  end

  // Exception vector to report: upstream bits plus our own address errors.
  always_comb begin
    exc_in           = i_except;
    exc_in[ADEL_BIT] = i_except[ADEL_BIT] | adel_in;
    exc_in[ADES_BIT] = i_except[ADES_BIT] | ades_in;
  end

  // A flush in IDLE refuses the op outright. Only clean memory ops reach the bus.
  assign accept = req_valid & req_ready & ~flush;
  assign go_bus = (is_load_in | is_store_in) & ~adel_in & ~ades_in & (i_except == '0);

  // Load extraction runs on the live bus_rdata so it can be captured on the
  // data_ok cycle. Stores and NONE fall through to zero.
  always_comb begin
    byte_sel  = bus_rdata[{k_q, 3'b000} +: 8];
    half_sel  = k_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    load_data = 32'd0;
    case (op_q)
      OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: load_data = {24'd0, byte_sel};
      OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU: load_data = {16'd0, half_sel};
      OP_LW:  load_data = bus_rdata;
`ifdef LSU_UNALIGNED_EN
      OP_LWL: begin
        case (k_q)
          2'd0:    load_data = {bus_rdata[7:0],  rt_q[23:0]};
          2'd1:    load_data = {bus_rdata[15:0], rt_q[15:0]};
          2'd2:    load_data = {bus_rdata[23:0], rt_q[7:0]};
          default: load_data = bus_rdata;
        endcase
      end
      OP_LWR: begin
        case (k_q)
          2'd0:    load_data = bus_rdata;
          2'd1:    load_data = {rt_q[31:24], bus_rdata[31:8]};
          2'd2:    load_data = {rt_q[31:16], bus_rdata[31:16]};
          default: load_data = {rt_q[31:8],  bus_rdata[31:24]};
        endcase
      end
`endif
      default: load_data = 32'd0;
    endcase
  end

  // Main FSM. Every output except resp_valid's flush gate is a register,
  // and it is updated on the transition into the state that owns it.
  // A flush that coincides with addr_ok cannot cancel the access, because the
  // bus has already taken it. In that case the unit drains like a RESP flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      bus_req      <= 1'b0;
      bus_wr       <= 1'b0;
      bus_wstrb    <= 4'b0000;
      bus_addr     <= '0;
      bus_wdata    <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_data    <= 32'd0;
      o_except     <= '0;
      op_q         <= 4'd0;
      k_q          <= 2'd0;
      exc_q        <= '0;
`ifdef LSU_UNALIGNED_EN
      rt_q         <= 32'd0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q      <= mem_op;
            k_q       <= k_in;
            exc_q     <= exc_in;
            req_ready <= 1'b0;
`ifdef LSU_UNALIGNED_EN
            rt_q      <= rt_data;
`endif
            if (go_bus) begin
              state     <= S_REQ;
              bus_req   <= 1'b1;
              bus_wr    <= is_store_in;
              bus_wstrb <= wstrb_in;
              bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              bus_wdata <= wdata_in;
            end else begin
              state        <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_data    <= 32'd0;
              o_except     <= exc_in;
            end
          end
        end
        S_REQ: begin
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            if (flush) begin
              if (bus_data_ok) begin
                state     <= S_IDLE;
                req_ready <= 1'b1;
              end else begin
                state <= S_DRAIN;
              end
            end else if (bus_data_ok) begin
              state        <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_data    <= load_data;
              o_except     <= exc_q;
            end else begin
              state <= S_RESP;
            end
          end else if (flush) begin
            bus_req   <= 1'b0;
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end
        end
        S_RESP: begin
          if (bus_data_ok) begin
            if (flush) begin
              state     <= S_IDLE;
              req_ready <= 1'b1;
            end else begin
              state        <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_data    <= load_data;
              o_except     <= exc_q;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus_data_ok) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          bus_req   <= 1'b0;
        end
      endcase
    end
  end

  // A flush during DONE swallows the response pulse.
  assign resp_valid = resp_valid_q & ~flush;

endmodule

// File: tb/tb_lsu_sram.sv
// ---------------------------------------------------------------------------
// tb_lsu_sram
//   Scoreboard bench for lsu_sram. The stimulus side predicts each op's
//   response and bus request from the architectural rules, and pushes them
//   into queues. A bus responder pops and checks the requests, and a response
//   monitor pops and checks resp_data / o_except / latency.
// ---------------------------------------------------------------------------
module tb_lsu_sram;
  localparam int EXC_W    = 7;
  localparam int ADEL_BIT = 1;
  localparam int ADES_BIT = 2;
`ifdef LSU_UNALIGNED_EN
  localparam bit UNAL = 1'b1;
`else
  localparam bit UNAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_ready, flush = 1'b0;
  logic [3:0] mem_op = 4'd0;
  logic [31:0] addr = 32'd0, rt_data = 32'd0;
  logic [EXC_W-1:0] i_except = '0, o_except;
  logic resp_valid;
  logic [31:0] resp_data;
  logic bus_req, bus_wr;
  logic [3:0] bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  lsu_sram #(.ADDR_W(32), .EXC_W(EXC_W), .ADEL_BIT(ADEL_BIT), .ADES_BIT(ADES_BIT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_op(mem_op), .addr(addr), .rt_data(rt_data), .i_except(i_except),
    .flush(flush), .resp_valid(resp_valid), .resp_data(resp_data), .o_except(o_except),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [EXC_W-1:0] exc; int acc_cyc; int lat; } resp_exp_t;
  typedef struct { logic wr; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata; } bus_exp_t;

  resp_exp_t resp_q[$];
  bus_exp_t  bus_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cfg_adly = 0, cfg_ddly = 0;
  logic [31:0] cfg_rdata = 32'd0;

  // Cycle index; it is stable from just after the rising edge to the next one.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model written from the architectural rules.
  function automatic bit op_is_load(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd5) || (UNAL && (op == 4'd9 || op == 4'd10));
  endfunction

  function automatic bit op_is_store(input logic [3:0] op);
    return (op >= 4'd6 && op <= 4'd8) || (UNAL && (op == 4'd11 || op == 4'd12));
  endfunction

  function automatic int op_align(input logic [3:0] op);
    if (op == 4'd3 || op == 4'd4 || op == 4'd7) return 2;
    if (op == 4'd5 || op == 4'd8) return 4;
    return 1;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input int k,
                                             input logic [31:0] m, input logic [31:0] rt);
    logic [31:0] b, h;
    b = (m >> (8 * k)) & 32'hFF;
    h = (m >> (16 * (k / 2))) & 32'hFFFF;
    case (op)
      4'd1:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      4'd2:    return b;
      4'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
      4'd4:    return h;
      4'd5:    return m;
      4'd9:    return (m << (8 * (3 - k))) | (rt & ((32'd1 << (8 * (3 - k))) - 32'd1));
      4'd10:   return (m >> (8 * k)) | (rt & ~(32'hFFFF_FFFF >> (8 * k)));
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] model_strobe(input logic [3:0] op, input int k);
    logic [31:0] s;
    case (op)
      4'd6:    s = 32'd1 << k;
      4'd7:    s = 32'd3 << k;
      4'd11:   s = (32'd1 << (k + 1)) - 32'd1;
      4'd12:   s = (32'hF << k) & 32'hF;
      default: s = 32'hF;
    endcase
    return s[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [3:0] op, input int k, input logic [31:0] rt);
    case (op)
      4'd6:    return (rt & 32'hFF) * 32'h0101_0101;
      4'd7:    return (rt & 32'hFFFF) * 32'h0001_0001;
      4'd11:   return rt >> (8 * (3 - k));
      4'd12:   return rt << (8 * k);
      default: return rt;
    endcase
  endfunction

  // Response monitor: every resp_valid pulse must match the oldest prediction.
  resp_exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (resp_q.size() == 0) begin
        checkOutput("resp_valid_unexpected", 32'(resp_valid), 32'd0);
      end else begin
        mon_e = resp_q.pop_front();
        checkOutput("resp_data", resp_data, mon_e.data);
        checkOutput("o_except", 32'(o_except), 32'(mon_e.exc));
        checkOutput("resp_latency", 32'(cyc - mon_e.acc_cyc), 32'(mon_e.lat));
      end
    end
  end

  // Bus responder: checks each new request against the prediction, holds
  // addr_ok low for cfg_adly cycles, then returns data cfg_ddly cycles later.
  int ph = 0, wcnt = 0;
  bit fresh = 1'b0;
  bus_exp_t held, bexp;
  always begin
    @(posedge clk);
    #1;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = $urandom;
    if (rst) begin
      ph = 0;
    end else begin
      if (ph == 1 && !bus_req) ph = 0;
      if (ph == 0 && bus_req) begin
        held = '{bus_wr, bus_addr, bus_wstrb, bus_wdata};
        if (bus_q.size() == 0) begin
          checkOutput("bus_req_unexpected", 32'(bus_req), 32'd0);
        end else begin
          bexp = bus_q.pop_front();
          checkOutput("bus_wr", 32'(bus_wr), 32'(bexp.wr));
          checkOutput("bus_addr", bus_addr, bexp.addr);
          if (bexp.wr) begin
            checkOutput("bus_wstrb", 32'(bus_wstrb), 32'(bexp.strb));
            checkOutput("bus_wdata", bus_wdata, bexp.wdata);
          end
        end
        ph = 1;
        fresh = 1'b1;
        wcnt = cfg_adly;
      end
      if (ph == 1) begin
        if (!fresh) begin
          checkOutput("bus_req_stable", 32'(bus_req), 32'd1);
          checkOutput("bus_addr_stable", bus_addr, held.addr);
          checkOutput("bus_wstrb_stable", 32'(bus_wstrb), 32'(held.strb));
          checkOutput("bus_wdata_stable", bus_wdata, held.wdata);
        end
        fresh = 1'b0;
        checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
        if (wcnt == 0) begin
          bus_addr_ok = 1'b1;
          if (cfg_ddly == 0) begin
            bus_data_ok = 1'b1;
            bus_rdata   = cfg_rdata;
            ph = 0;
          end else begin
            ph = 2;
            wcnt = cfg_ddly;
          end
        end else begin
          wcnt--;
        end
      end else if (ph == 2) begin
        wcnt--;
        if (wcnt == 0) begin
          bus_data_ok = 1'b1;
          bus_rdata   = cfg_rdata;
          ph = 0;
        end
      end
    end
  end

  // Predicts the op, then presents it for exactly one cycle. It returns one
  // cycle after acceptance.
  task automatic sendOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rt,
                        input logic [EXC_W-1:0] exc, input int adly, input int ddly,
                        input logic [31:0] rdata, input bit push_resp,
                        output int acc, output int lat);
    bit ld, st, err, use_bus;
    int k;
    resp_exp_t re;
    bus_exp_t be;
    ld = op_is_load(op);
    st = op_is_store(op);
    k = int'(a % 4);
    err = (ld || st) && ((a % op_align(op)) != 0);
    use_bus = (ld || st) && !err && (exc == '0);
    lat = use_bus ? 2 + adly + ddly : 1;
    re.data = (use_bus && ld) ? model_load(op, k, rdata, rt) : 32'd0;
    re.exc = exc;
    if (err && ld) re.exc[ADEL_BIT] = 1'b1;
    if (err && st) re.exc[ADES_BIT] = 1'b1;
    cfg_adly = adly;
    cfg_ddly = ddly;
    cfg_rdata = rdata;
    if (use_bus) begin
      be = '{st, a & 32'hFFFF_FFFC, model_strobe(op, k), model_wdata(op, k, rt)};
      bus_q.push_back(be);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    mem_op = op;
    addr = a;
    rt_data = rt;
    i_except = exc;
    acc = cyc;
    re.acc_cyc = cyc;
    re.lat = lat;
    if (push_resp) resp_q.push_back(re);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_op = 4'($urandom);
    addr = $urandom;
    rt_data = $urandom;
    i_except = EXC_W'($urandom);
  endtask

  task automatic waitIdle(input int acc, input int lat);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready) checkOutput("ready_timeout", 32'(req_ready), 32'd1);
    else checkOutput("ready_return_cycle", 32'(cyc - acc), 32'(lat + 1));
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rt,
                               input logic [EXC_W-1:0] exc, input int adly, input int ddly,
                               input logic [31:0] rdata);
    int acc, lat;
    sendOp(op, a, rt, exc, adly, ddly, rdata, 1'b1, acc, lat);
    waitIdle(acc, lat);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, lat;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_bus_req", 32'(bus_req), 32'd0);
    checkOutput("reset_resp_data", resp_data, 32'd0);
    checkOutput("reset_o_except", 32'(o_except), 32'd0);
    checkOutput("reset_bus_wstrb", 32'(bus_wstrb), 32'd0);

    $display("[TB] directed cases");
    applyStimulus(4'd1, 32'h0000_1003, 32'h0, '0, 0, 1, 32'h80FF_1234);
    checkOutput("lb_sign_extend", resp_data, 32'hFFFF_FF80);
    applyStimulus(4'd7, 32'h0000_2002, 32'h0000_ABCD, '0, 0, 1, 32'h5555_5555);
    checkOutput("sh_resp_zero", resp_data, 32'd0);
    applyStimulus(4'd5, 32'h0000_3001, 32'h0, '0, 0, 1, 32'h0);
    checkOutput("lw_adel", 32'(o_except), 32'h2);
    applyStimulus(4'd8, 32'h0000_9000, 32'hCAFE_F00D, '0, 5, 1, 32'h0);
    applyStimulus(4'd6, 32'h0000_9001, 32'hDEAD_BE5A, '0, 0, 0, 32'h0);
    applyStimulus(4'd3, 32'h0000_9006, 32'h0, '0, 1, 0, 32'h9abc_1234);
    applyStimulus(4'd0, 32'h0000_0000, 32'h0, '0, 0, 0, 32'h0);
    applyStimulus(4'd14, 32'h0000_0010, 32'h0, '0, 0, 0, 32'h0);
    applyStimulus(4'd2, 32'h0000_0020, 32'h0, 7'h10, 0, 0, 32'h0);
`ifdef LSU_UNALIGNED_EN
    applyStimulus(4'd9, 32'h0000_4001, 32'hAABB_CCDD, '0, 0, 1, 32'h1122_3344);
    checkOutput("lwl_merge", resp_data, 32'h3344_CCDD);
    applyStimulus(4'd12, 32'h0000_4002, 32'h1234_5678, '0, 0, 1, 32'h0);
`endif

    // Flush while waiting for data: the access drains with no response.
    sendOp(4'd5, 32'h0000_5000, 32'h0, '0, 0, 4, 32'h1111_2222, 1'b0, acc, lat);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("drain_ready_busy", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("drain_ready_after", 32'(req_ready), 32'd1);

    // Flush before addr_ok: the request is withdrawn.
    sendOp(4'd8, 32'h0000_6000, 32'h1234_5678, '0, 6, 1, 32'h0, 1'b0, acc, lat);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("req_flush_bus_req", 32'(bus_req), 32'd0);
    checkOutput("req_flush_ready", 32'(req_ready), 32'd1);

    // Flush in DONE suppresses the pulse (the monitor flags any response).
    sendOp(4'd5, 32'h0000_7002, 32'h0, '0, 0, 0, 32'h0, 1'b0, acc, lat);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("done_flush_ready", 32'(req_ready), 32'd1);

    // Flush in IDLE refuses the op.
    req_valid = 1'b1; mem_op = 4'd1; addr = 32'h0; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    checkOutput("idle_flush_ready", 32'(req_ready), 32'd1);
    checkOutput("idle_flush_bus_req", 32'(bus_req), 32'd0);

    // Reset in the middle of a pending request.
    sendOp(4'd8, 32'h0000_8000, 32'h0BAD_F00D, '0, 20, 1, 32'h0, 1'b0, acc, lat);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midreset_bus_req", 32'(bus_req), 32'd0);
    checkOutput("midreset_ready", 32'(req_ready), 32'd1);
    checkOutput("midreset_resp_data", resp_data, 32'd0);
    checkOutput("midreset_o_except", 32'(o_except), 32'd0);

    $display("[TB] random cases");
    for (int i = 0; i < 150; i++) begin
      logic [EXC_W-1:0] e;
      e = ($urandom_range(7, 0) == 0) ? EXC_W'($urandom) : '0;
      applyStimulus(4'($urandom_range(15, 0)), $urandom, $urandom, e,
                    $urandom_range(3, 0), $urandom_range(3, 0), $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resp_q_left", 32'(resp_q.size()), 32'd0);
    checkOutput("bus_q_left", 32'(bus_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
